// File: rtl/combiner.sv
// Receive-side time-slot combiner: deserializes an LSB-first bit stream into
// four per-slot channel registers. Optional per-channel byte counters: COMBINER_STATS_EN.
module combiner #(
  parameter int unsigned SLOT0_LEN = 88,
  parameter int unsigned SLOT1_LEN = 80,
  parameter int unsigned SLOT2_LEN = 56,
  parameter int unsigned SLOT3_LEN = 32,
  parameter int unsigned LAT       = 0
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       holder,
  input  logic       din,
  input  logic [3:0] en,
  output logic [7:0] ch0_data,
  output logic [7:0] ch1_data,
  output logic [7:0] ch2_data,
  output logic [7:0] ch3_data,
  output logic [3:0] ch_valid,
  output logic [1:0] slot,
  output logic       frame_start,
  output logic       busy
`ifdef COMBINER_STATS_EN
  ,
  output logic [7:0] rx_cnt0,
  output logic [7:0] rx_cnt1,
  output logic [7:0] rx_cnt2,
  output logic [7:0] rx_cnt3
`endif
);

  // state | meaning
  // IDLE  | link stopped, waiting for holder rise
  // ALIGN | holder high, skipping LAT link-latency cycles (din ignored)
  // RUN   | sampling din every edge, tracking bit/slot position
  typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_RUN} state_t;

  localparam logic [7:0] L0_LAST = 8'(SLOT0_LEN - 1);
  localparam logic [7:0] L1_LAST = 8'(SLOT1_LEN - 1);
  localparam logic [7:0] L2_LAST = 8'(SLOT2_LEN - 1);
  localparam logic [7:0] L3_LAST = 8'(SLOT3_LEN - 1);
  localparam logic [3:0] LAT_C   = 4'(LAT);

  state_t      r_state;
  state_t      w_next;
  logic [6:0]  r_sr;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_slot_cnt;
  logic [3:0]  r_lat_cnt;
  logic [1:0]  r_slot;
  logic [3:0]  r_valid;
  logic        r_frame_start;
  logic [7:0]  r_ch_data [4];
  logic [7:0]  w_byte;
  logic [7:0]  w_slot_last_cnt;
  logic        w_sample;
  logic        w_slot_last;
  logic        w_accept;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (holder) w_next = (LAT_C == 4'd0) ? S_RUN : S_ALIGN;
      S_ALIGN: begin
        if (!holder)                 w_next = S_IDLE;
        else if (r_lat_cnt == LAT_C) w_next = S_RUN;
      end
      S_RUN:   if (!holder) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_slot_last_cnt = L0_LAST;
    unique case (r_slot)
      2'd0: w_slot_last_cnt = L0_LAST;
      2'd1: w_slot_last_cnt = L1_LAST;
      2'd2: w_slot_last_cnt = L2_LAST;
      2'd3: w_slot_last_cnt = L3_LAST;
      default: w_slot_last_cnt = L0_LAST;
    endcase
  end

  // The edge that enters RUN already carries frame bit 0, so sampling follows next-state.
  assign w_sample    = (w_next == S_RUN);
  assign w_byte      = {din, r_sr};
  assign w_slot_last = (r_slot_cnt == w_slot_last_cnt);
  assign w_accept    = w_sample && (r_bit_cnt == 3'd7) && en[r_slot];

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr          <= '0;
      r_bit_cnt     <= '0;
      r_slot_cnt    <= '0;
      r_lat_cnt     <= '0;
      r_slot        <= '0;
      r_valid       <= '0;
      r_frame_start <= 1'b0;
      for (int i = 0; i < 4; i++) r_ch_data[i] <= '0;
    end else begin
      r_valid       <= '0;
      r_frame_start <= 1'b0;
      if (!holder) begin
        r_sr       <= '0;
        r_bit_cnt  <= '0;
        r_slot_cnt <= '0;
        r_lat_cnt  <= '0;
        r_slot     <= '0;
      end else if (w_sample) begin
        r_sr      <= w_byte[7:1];
        r_bit_cnt <= r_bit_cnt + 3'd1;
        r_lat_cnt <= '0;
        if (w_slot_last) begin
          r_slot_cnt <= '0;
          r_slot     <= r_slot + 2'd1;
          if (r_slot == 2'd3) r_frame_start <= 1'b1;
        end else begin
          r_slot_cnt <= r_slot_cnt + 8'd1;
        end
        // The byte belongs to the slot in effect during its bits, i.e. before any advance.
        if (w_accept) begin
          r_ch_data[r_slot] <= w_byte;
          r_valid           <= 4'b0001 << r_slot;
        end
      end else begin
        r_lat_cnt <= (r_state == S_IDLE) ? 4'd1 : r_lat_cnt + 4'd1;
      end
    end
  end

  assign ch0_data    = r_ch_data[0];
  assign ch1_data    = r_ch_data[1];
  assign ch2_data    = r_ch_data[2];
  assign ch3_data    = r_ch_data[3];
  assign ch_valid    = r_valid;
  assign slot        = r_slot;
  assign frame_start = r_frame_start;
  assign busy        = (r_state == S_RUN);

`ifdef COMBINER_STATS_EN
  logic [7:0] r_rx_cnt [4];

  // Holder drops do not clear these; only reset does.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_rx_cnt[i] <= '0;
    end else if (w_accept) begin
      r_rx_cnt[r_slot] <= r_rx_cnt[r_slot] + 8'd1;
    end
  end

  assign rx_cnt0 = r_rx_cnt[0];
  assign rx_cnt1 = r_rx_cnt[1];
  assign rx_cnt2 = r_rx_cnt[2];
  assign rx_cnt3 = r_rx_cnt[3];
`endif

endmodule

// File: tb/tb_combiner.sv
// Self-checking bench for combiner: scoreboard of expected channel bytes plus
// directed checks of slot timing, frame_start, holder drop, reset and LAT=2 alignment.
module tb_combiner;

  logic       sysclk = 1'b0;
  logic       rst_n;
  logic       holder, din, holder2, din2;
  logic [3:0] en;
  logic [7:0] ch0_data, ch1_data, ch2_data, ch3_data;
  logic [3:0] ch_valid;
  logic [1:0] slot;
  logic       frame_start, busy;
  logic [7:0] ch0_data2, ch1_data2, ch2_data2, ch3_data2;
  logic [3:0] ch_valid2;
  logic [1:0] slot2;
  logic       frame_start2, busy2;
`ifdef COMBINER_STATS_EN
  logic [7:0] rx_cnt0, rx_cnt1, rx_cnt2, rx_cnt3;
  logic [7:0] rx2_cnt0, rx2_cnt1, rx2_cnt2, rx2_cnt3;
`endif

  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] d;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   strobe_cnt [4];
  int   n_push [4];
  int   fs_cnt;

  always #5 sysclk = ~sysclk;

  combiner #(.LAT(0)) dut (
    .sysclk(sysclk), .rst_n(rst_n), .holder(holder), .din(din), .en(en),
    .ch0_data(ch0_data), .ch1_data(ch1_data), .ch2_data(ch2_data), .ch3_data(ch3_data),
    .ch_valid(ch_valid), .slot(slot), .frame_start(frame_start), .busy(busy)
`ifdef COMBINER_STATS_EN
    , .rx_cnt0(rx_cnt0), .rx_cnt1(rx_cnt1), .rx_cnt2(rx_cnt2), .rx_cnt3(rx_cnt3)
`endif
  );

  combiner #(.LAT(2)) dut2 (
    .sysclk(sysclk), .rst_n(rst_n), .holder(holder2), .din(din2), .en(4'b1111),
    .ch0_data(ch0_data2), .ch1_data(ch1_data2), .ch2_data(ch2_data2), .ch3_data(ch3_data2),
    .ch_valid(ch_valid2), .slot(slot2), .frame_start(frame_start2), .busy(busy2)
`ifdef COMBINER_STATS_EN
    , .rx_cnt0(rx2_cnt0), .rx_cnt1(rx2_cnt1), .rx_cnt2(rx2_cnt2), .rx_cnt3(rx2_cnt3)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int slot_of(input int j);
    if (j < 11) return 0;
    if (j < 21) return 1;
    if (j < 28) return 2;
    return 3;
  endfunction

  function automatic logic [7:0] ch_data_of(input logic [1:0] c);
    case (c)
      2'd0: return ch0_data;
      2'd1: return ch1_data;
      2'd2: return ch2_data;
      default: return ch3_data;
    endcase
  endfunction

  always @(negedge sysclk) begin
    if (rst_n === 1'b1 && ch_valid !== 4'b0000) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_strobe", 32'(ch_valid), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("sb_valid", 32'(ch_valid), 32'(4'b0001 << mon_e.ch));
        check("sb_data", 32'(ch_data_of(mon_e.ch)), 32'(mon_e.d));
      end
    end
  end

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    din = b;
    tick();
    for (int c = 0; c < 4; c++) if (ch_valid[c]) strobe_cnt[c]++;
    if (frame_start) fs_cnt++;
  endtask

  task automatic expect_byte(input logic [7:0] d, input int s);
    if (en[s]) begin
      sb.push_back('{ch: 2'(s), d: d});
      n_push[s]++;
    end
  endtask

  task automatic clear_counts();
    for (int c = 0; c < 4; c++) strobe_cnt[c] = 0;
    fs_cnt = 0;
  endtask

  task automatic send_frame(input logic [7:0] base, input bit chk);
    logic [7:0] d;
    int e;
    for (int j = 0; j < 32; j++) begin
      d = base + 8'(j);
      expect_byte(d, slot_of(j));
      for (int b = 0; b < 8; b++) begin
        send_bit(d[b]);
        e = 8 * j + b;
        if (chk) begin
          if (e == 0)   check("fs_not_first_entry", 32'(frame_start), 32'd0);
          if (e == 86)  check("slot_before_87", 32'(slot), 32'd0);
          if (e == 87)  check("slot_after_87", 32'(slot), 32'd1);
          if (e == 95)  check("ch1_first_byte", 32'(ch1_data), 32'h0B);
          if (e == 254) check("fs_before_255", 32'(frame_start), 32'd0);
          if (e == 255) begin
            check("fs_after_255", 32'(frame_start), 32'd1);
            check("slot_wrap", 32'(slot), 32'd0);
          end
        end
      end
    end
  endtask

  initial begin
    logic [7:0] d;
    for (int c = 0; c < 4; c++) n_push[c] = 0;
    clear_counts();
    rst_n = 1'b0; holder = 1'b0; din = 1'b0; holder2 = 1'b0; din2 = 1'b0; en = 4'b1111;
    #1;
    check("rst_outputs", 32'({ch0_data, ch1_data, ch2_data, ch3_data}), 32'd0);
    check("rst_ctrl", 32'({ch_valid, slot, frame_start, busy}), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    // Single byte 0xA5 straight after holder rise with LAT=0.
    holder = 1'b1;
    d = 8'hA5;
    expect_byte(d, 0);
    for (int b = 0; b < 8; b++) send_bit(d[b]);
    check("a5_data", 32'(ch0_data), 32'hA5);
    check("a5_valid", 32'(ch_valid), 32'b0001);
    check("a5_busy", 32'(busy), 32'd1);
    holder = 1'b0;
    tick();
    check("a5_valid_one_cycle", 32'(ch_valid), 32'd0);
    check("drop_busy", 32'(busy), 32'd0);

    // Full frame of incrementing bytes, all channels enabled.
    holder = 1'b1;
    clear_counts();
    send_frame(8'h00, 1'b1);
    check("f1_cnt0", 32'(strobe_cnt[0]), 32'd11);
    check("f1_cnt1", 32'(strobe_cnt[1]), 32'd10);
    check("f1_cnt2", 32'(strobe_cnt[2]), 32'd7);
    check("f1_cnt3", 32'(strobe_cnt[3]), 32'd4);
    check("f1_fs_count", 32'(fs_cnt), 32'd1);

    // Second frame with slot 1 disabled.
    en = 4'b1101;
    clear_counts();
    send_frame(8'h40, 1'b0);
    check("f2_cnt0", 32'(strobe_cnt[0]), 32'd11);
    check("f2_cnt1", 32'(strobe_cnt[1]), 32'd0);
    check("f2_cnt2", 32'(strobe_cnt[2]), 32'd7);
    check("f2_cnt3", 32'(strobe_cnt[3]), 32'd4);
    check("f2_ch1_held", 32'(ch1_data), 32'h14);
    check("f2_ch2_last", 32'(ch2_data), 32'h5B);
    check("f2_ch3_last", 32'(ch3_data), 32'h5F);
    check("f2_fs_count", 32'(fs_cnt), 32'd1);

    // Holder drop after bit 4 of a byte.
    en = 4'b1111;
    clear_counts();
    d = 8'hFF;
    for (int b = 0; b < 5; b++) send_bit(d[b]);
    holder = 1'b0;
    send_bit(1'b1);
    check("drop_busy_next", 32'(busy), 32'd0);
    check("drop_slot", 32'(slot), 32'd0);
    check("drop_ch0_held", 32'(ch0_data), 32'h4A);

    // Holder drop on the last bit of a byte: no strobe.
    holder = 1'b1;
    d = 8'h11;
    for (int b = 0; b < 7; b++) send_bit(d[b]);
    holder = 1'b0;
    send_bit(d[7]);
    check("drop_last_bit_valid", 32'(ch_valid), 32'd0);
    check("drop_last_bit_ch0", 32'(ch0_data), 32'h4A);
    check("drop_no_strobes", 32'(strobe_cnt[0]), 32'd0);

    // Realign from edge 0 with 0x3C.
    holder = 1'b1;
    d = 8'h3C;
    expect_byte(d, 0);
    for (int b = 0; b < 8; b++) send_bit(d[b]);
    check("realign_ch0", 32'(ch0_data), 32'h3C);
    check("realign_valid", 32'(ch_valid), 32'b0001);
`ifdef COMBINER_STATS_EN
    check("stats0", 32'(rx_cnt0), 32'(8'(n_push[0])));
    check("stats1", 32'(rx_cnt1), 32'(8'(n_push[1])));
    check("stats2", 32'(rx_cnt2), 32'(8'(n_push[2])));
    check("stats3", 32'(rx_cnt3), 32'(8'(n_push[3])));
`endif

    // Asynchronous reset mid-byte.
    for (int b = 0; b < 3; b++) send_bit(1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_data", 32'({ch0_data, ch1_data, ch2_data, ch3_data}), 32'd0);
    check("midrst_ctrl", 32'({ch_valid, slot, frame_start, busy}), 32'd0);
    holder = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // LAT=2 instance: two leading 1s are ignored.
    holder2 = 1'b1;
    din2 = 1'b1;
    tick();
    check("lat2_align_busy0", 32'(busy2), 32'd0);
    tick();
    check("lat2_align_busy1", 32'(busy2), 32'd0);
    din2 = 1'b0;
    tick();
    check("lat2_run_busy", 32'(busy2), 32'd1);
    for (int b = 1; b < 8; b++) begin
      tick();
      if (b == 5) check("lat2_no_early_valid", 32'(ch_valid2), 32'd0);
    end
    check("lat2_valid", 32'(ch_valid2), 32'b0001);
    check("lat2_byte0", 32'(ch0_data2), 32'h00);
    d = 8'h5A;
    for (int b = 0; b < 8; b++) begin
      din2 = d[b];
      tick();
    end
    check("lat2_byte1", 32'(ch0_data2), 32'h5A);
    check("lat2_other_ch", 32'({ch1_data2, ch2_data2, ch3_data2, slot2, frame_start2}), 32'd0);
`ifdef COMBINER_STATS_EN
    check("lat2_stats0", 32'(rx2_cnt0), 32'd2);
    check("lat2_stats_other", 32'({rx2_cnt1, rx2_cnt2, rx2_cnt3}), 32'd0);
`endif
    holder2 = 1'b0;
    tick();
    tick();

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
